// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vending_param controller.
//   - state_t    : FSM state encodings (IDLE, CREDIT, VEND, CHANGE)
//   - SEL_*      : coin_sel codes for the three denominations and the invalid code
//   - max3       : helper used to size the credit register from the coin values
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CREDIT = 2'b01,
    VEND   = 2'b10,
    CHANGE = 2'b11
  } state_t;

  localparam logic [1:0] SEL_COIN0   = 2'b00;
  localparam logic [1:0] SEL_COIN1   = 2'b01;
  localparam logic [1:0] SEL_COIN2   = 2'b10;
  localparam logic [1:0] SEL_INVALID = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vend_stock_ctr.sv
// vend_stock_ctr: product stock counter for vending_param.
// Loaded with STOCK_INIT on reset and decremented once per sale; sold_out is
// decoded from the registered count.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-high reset
//   take     in  one product leaves the machine this cycle (FSM entering VEND)
//   sold_out out stock count is zero
module vend_stock_ctr #(
  parameter int STOCK_INIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic take,
  output logic sold_out
);

  // At least one bit so a zero-stock configuration still elaborates.
  localparam int SW = (STOCK_INIT < 1) ? 1 : $clog2(STOCK_INIT + 1);

  logic [SW-1:0] stock;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stock <= SW'(STOCK_INIT);
    end else if (take && (stock != '0)) begin
      stock <= stock - SW'(1);
    end
  end

  assign sold_out = (stock == '0);

endmodule

// File: rtl/vending_param.sv
// vending_param: parametrised vending-machine controller.
// Accepts one coin per cycle from three denominations (COIN0/1/2), accumulates
// credit up to PRICE, pulses vend, then pays back any remainder one Re.1 coin
// per cycle on change. cancel in CREDIT refunds the whole credit.
// Optional feature macro: VEND_STOCK_EN -- adds a stock counter (STOCK_INIT
// products) that raises sold_out at zero, after which every coin is rejected.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   coin_valid in   one coin presented this cycle
//   coin_sel   in   coin type (2'b11 invalid)
//   cancel     in   refund request
//   vend       out  product dispense pulse
//   change     out  return one Re.1 coin this cycle
//   coin_rej   out  previous cycle's coin was not accepted (registered pulse)
//   busy       out  FSM in VEND or CHANGE
//   sold_out   out  stock exhausted (tied 0 without VEND_STOCK_EN)
//   credit     out  current credit in rupees
module vending_param
  import vend_pkg::*;
#(
  parameter int PRICE      = 3,
  parameter int COIN0      = 1,
  parameter int COIN1      = 2,
  parameter int COIN2      = 5,
  parameter int STOCK_INIT = 15,
  // Widest credit is PRICE-1 plus the largest coin, so this never overflows.
  localparam int CW = $clog2(PRICE + max3(COIN0, COIN1, COIN2))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_valid,
  input  logic [1:0]    coin_sel,
  input  logic          cancel,
  output logic          vend,
  output logic          change,
  output logic          coin_rej,
  output logic          busy,
  output logic          sold_out,
  output logic [CW-1:0] credit
);

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

  function automatic logic [CW-1:0] coin_value(input logic [1:0] sel);
    case (sel)
      SEL_COIN0: coin_value = CW'(COIN0);
      SEL_COIN1: coin_value = CW'(COIN1);
      SEL_COIN2: coin_value = CW'(COIN2);
      default:   coin_value = '0;
    endcase
  endfunction

  state_t        state, state_nxt;
  logic [CW-1:0] credit_nxt;
  logic [CW-1:0] sum;
  logic          accept;
  logic          take;
  logic          rej_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      credit   <= '0;
      coin_rej <= 1'b0;
    end else begin
      state    <= state_nxt;
      credit   <= credit_nxt;
      coin_rej <= rej_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    take       = 1'b0;
    sum        = credit + coin_value(coin_sel);
    // cancel always beats a simultaneous coin, even in IDLE where cancel itself is a no-op.
    accept     = coin_valid && !cancel && !sold_out && (coin_sel != SEL_INVALID) &&
                 ((state == IDLE) || (state == CREDIT));
    rej_nxt    = coin_valid && !accept;

    case (state)
      IDLE, CREDIT: begin
        if ((state == CREDIT) && cancel) begin
          state_nxt = CHANGE;
        end else if (accept) begin
          if (sum >= PRICE_C) begin
            state_nxt  = VEND;
            credit_nxt = sum - PRICE_C;
            take       = 1'b1;
          end else begin
            state_nxt  = CREDIT;
            credit_nxt = sum;
          end
        end
      end
      VEND: begin
        state_nxt = (credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        credit_nxt = credit - CW'(1);
        if (credit <= CW'(1)) begin
          state_nxt  = IDLE;
          credit_nxt = '0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        credit_nxt = '0;
      end
    endcase
  end

  assign vend   = (state == VEND);
  assign change = (state == CHANGE);
  assign busy   = vend | change;

`ifdef VEND_STOCK_EN
  vend_stock_ctr #(
    .STOCK_INIT(STOCK_INIT)
  ) u_stock (
    .clk      (clk),
    .rst      (rst),
    .take     (take),
    .sold_out (sold_out)
  );
`else
  // Without a stock counter the machine never sells out; a negative stock
  // setting is the only way to mark it permanently unavailable.
  if (STOCK_INIT >= 0) begin : g_no_stock
    assign sold_out = 1'b0;
  end else begin : g_bad_stock
    assign sold_out = 1'b1;
  end
  logic unused_take;
  assign unused_take = take;
`endif

endmodule

// File: tb/tb_vending_param.sv
// tb_vending_param: directed testbench for vending_param (PRICE=3, coins 1/2/5).
// With VEND_STOCK_EN defined the DUT is built with STOCK_INIT=1 and the bench
// expects sold_out after the first sale and rejection of the following coin.
module tb_vending_param;

`ifdef VEND_STOCK_EN
  localparam bit STOCK_EN   = 1'b1;
  localparam int STOCK_INIT = 1;
`else
  localparam bit STOCK_EN   = 1'b0;
  localparam int STOCK_INIT = 15;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       cancel;
  logic       vend;
  logic       change;
  logic       coin_rej;
  logic       busy;
  logic       sold_out;
  logic [2:0] credit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vending_param #(
    .PRICE      (3),
    .COIN0      (1),
    .COIN1      (2),
    .COIN2      (5),
    .STOCK_INIT (STOCK_INIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_valid (coin_valid),
    .coin_sel   (coin_sel),
    .cancel     (cancel),
    .vend       (vend),
    .change     (change),
    .coin_rej   (coin_rej),
    .busy       (busy),
    .sold_out   (sold_out),
    .credit     (credit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int e_vend, input int e_change,
                            input int e_rej, input int e_credit);
    check({tag, ".vend"},     32'(vend),     32'(e_vend));
    check({tag, ".change"},   32'(change),   32'(e_change));
    check({tag, ".coin_rej"}, 32'(coin_rej), 32'(e_rej));
    check({tag, ".credit"},   32'(credit),   32'(e_credit));
  endtask

  // Present inputs for one clock, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [1:0] s, input logic c);
    coin_valid = v;
    coin_sel   = s;
    cancel     = c;
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    coin_sel   = 2'b00;
    cancel     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    coin_valid = 1'b0;
    coin_sel   = 2'b00;
    cancel     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0);
    check("reset.busy",     32'(busy),     32'd0);
    check("reset.sold_out", 32'(sold_out), 32'd0);
    rst = 1'b0;

    // Coins 1 then 2: exact price, no change.
    step(1'b1, 2'b00, 1'b0);
    check_outs("c12.first", 0, 0, 0, 1);
    step(1'b1, 2'b01, 1'b0);
    check_outs("c12.vend", 1, 0, 0, 0);
    check("c12.busy",     32'(busy),     32'd1);
    check("c12.sold_out", 32'(sold_out), 32'(STOCK_EN));
    step(1'b0, 2'b00, 1'b0);
    check_outs("c12.idle", 0, 0, 0, 0);
    check("c12.idle_busy", 32'(busy), 32'd0);
    // Next coin: rejected when sold out, otherwise accepted.
    step(1'b1, 2'b00, 1'b0);
    if (STOCK_EN) check_outs("c12.after", 0, 0, 1, 0);
    else          check_outs("c12.after", 0, 0, 0, 1);
    do_reset();

    // Coins 2 then 2: vend with one rupee change.
    step(1'b1, 2'b01, 1'b0);
    check_outs("c22.first", 0, 0, 0, 2);
    step(1'b1, 2'b01, 1'b0);
    check_outs("c22.vend", 1, 0, 0, 1);
    step(1'b0, 2'b00, 1'b0);
    check_outs("c22.chg1", 0, 1, 0, 1);
    check("c22.chg1_busy", 32'(busy), 32'd1);
    step(1'b0, 2'b00, 1'b0);
    check_outs("c22.idle", 0, 0, 0, 0);
    do_reset();

    // Coin 5: vend, two change pulses, coin during change rejected.
    step(1'b1, 2'b10, 1'b0);
    check_outs("c5.vend", 1, 0, 0, 2);
    step(1'b0, 2'b00, 1'b0);
    check_outs("c5.chg1", 0, 1, 0, 2);
    step(1'b1, 2'b00, 1'b0);
    check_outs("c5.chg2", 0, 1, 1, 1);
    step(1'b0, 2'b00, 1'b0);
    check_outs("c5.idle", 0, 0, 0, 0);
    check("c5.idle_busy", 32'(busy), 32'd0);
    do_reset();

    // Coin 2 then cancel: full refund, no vend.
    step(1'b1, 2'b01, 1'b0);
    check_outs("cancel.coin", 0, 0, 0, 2);
    step(1'b0, 2'b00, 1'b1);
    check_outs("cancel.chg1", 0, 1, 0, 2);
    step(1'b0, 2'b00, 1'b0);
    check_outs("cancel.chg2", 0, 1, 0, 1);
    step(1'b0, 2'b00, 1'b0);
    check_outs("cancel.idle", 0, 0, 0, 0);

    // Cancel and coin together: coin rejected, only prior credit refunded.
    step(1'b1, 2'b00, 1'b0);
    check_outs("cc.coin", 0, 0, 0, 1);
    step(1'b1, 2'b01, 1'b1);
    check_outs("cc.both", 0, 1, 1, 1);
    step(1'b0, 2'b00, 1'b0);
    check_outs("cc.idle", 0, 0, 0, 0);

    // Cancel in IDLE does nothing.
    step(1'b0, 2'b00, 1'b1);
    check_outs("idle_cancel", 0, 0, 0, 0);
    check("idle_cancel.busy", 32'(busy), 32'd0);

    // Invalid coin code never changes credit.
    step(1'b1, 2'b11, 1'b0);
    check_outs("inv.idle", 0, 0, 1, 0);
    step(1'b1, 2'b00, 1'b0);
    check_outs("inv.coin1", 0, 0, 0, 1);
    step(1'b1, 2'b11, 1'b0);
    check_outs("inv.credit", 0, 0, 1, 1);

    // 1 + 5 = 6: vend with 3 change, then reset in the middle of change.
    step(1'b1, 2'b10, 1'b0);
    check_outs("rst.vend", 1, 0, 0, 3);
    step(1'b0, 2'b00, 1'b0);
    check_outs("rst.chg1", 0, 1, 0, 3);
    rst = 1'b1;
    #1;
    check_outs("rst.async", 0, 0, 0, 0);
    check("rst.async_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step(1'b0, 2'b00, 1'b0);
    check_outs("rst.after", 0, 0, 0, 0);
    check("rst.sold_out", 32'(sold_out), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
